// File: rtl/riscv_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Holds register offsets, STATUS bit positions and the TX state encoding.
package riscv_mmio_pkg;

  localparam logic [3:0] UART_OFS_TXDATA = 4'h0;
  localparam logic [3:0] UART_OFS_STATUS = 4'h4;
  localparam logic [3:0] UART_OFS_DIV    = 4'h8;
  localparam logic [3:0] UART_OFS_IE     = 4'hC;

  localparam int UART_ST_BUSY    = 0;
  localparam int UART_ST_FULL    = 1;
  localparam int UART_ST_EMPTY   = 2;
  localparam int UART_ST_OVF     = 3;
  localparam int UART_ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_t;

  // A zero divisor would stall the baud counter, so it is stored as 1.
  function automatic logic [15:0] uart_div_sanitize(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; push is ignored when full,
// pop is ignored when empty. Data output shows the head entry combinationally.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter sitting beside data memory on the store path.
// Define UART_TX_IRQ_EN to add the IE register at 0xC and the registered irq output.
module uart_tx_mmio
  import riscv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  output logic        Sel,
  output logic [31:0] RdData,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]     ofs;
  logic           wr_en, wr_txdata, wr_status, wr_div;
  logic           ovf_q;
  logic [15:0]    div_q;

  logic           fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_cnt;

  uart_tx_state_t state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           tx_d, tick, busy;

  logic           unused_bits;
  assign unused_bits = ^DataWr[31:16];

  assign ofs       = Address[3:0];
  assign Sel       = (Address[31:4] == BASE_ADDR[31:4]);
  assign wr_en     = Sel & DMWr;
  assign wr_txdata = wr_en & (ofs == UART_OFS_TXDATA);
  assign wr_status = wr_en & (ofs == UART_OFS_STATUS);
  assign wr_div    = wr_en & (ofs == UART_OFS_DIV);
  assign busy      = (state_q != TX_IDLE);
  assign tick      = (baud_q == 16'd0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (DataWr[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Any push that finds the FIFO full sets OVF, including one paired with a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      div_q <= DIV_RESET;
    end else begin
      if (wr_txdata && fifo_full) ovf_q <= 1'b1;
      else if (wr_status)         ovf_q <= 1'b0;
      if (wr_div) div_q <= uart_div_sanitize(DataWr[15:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx      <= tx_d;
    end
  end

  // The divisor is sampled only on reload, so a DIV write takes effect at the next bit boundary.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          state_d  = TX_START;
          baud_d   = div_q - 16'd1;
        end
      end
      TX_START: begin
        if (tick) begin
          state_d = TX_DATA;
          idx_d   = 3'd0;
          baud_d  = div_q - 16'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tick) begin
          baud_d = div_q - 16'd1;
          if (idx_q == 3'd7) state_d = TX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            state_d  = TX_START;
            baud_d   = div_q - 16'd1;
          end else begin
            state_d = TX_IDLE;
            baud_d  = 16'd0;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level follows the next state so tx changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shreg_d[idx_d];
      default:  tx_d = 1'b1;
    endcase
  end

`ifdef UART_TX_IRQ_EN
  logic ie_q, irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && (ofs == UART_OFS_IE)) ie_q <= DataWr[0];
      irq_q <= ie_q & fifo_empty & ~busy;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    RdData = '0;
    if (Sel) begin
      case (ofs)
        UART_OFS_STATUS: begin
          RdData[UART_ST_BUSY]              = busy;
          RdData[UART_ST_FULL]              = fifo_full;
          RdData[UART_ST_EMPTY]             = fifo_empty;
          RdData[UART_ST_OVF]               = ovf_q;
          RdData[UART_ST_CNT_LSB +: 4]      = 4'(fifo_cnt);
        end
        UART_OFS_DIV: RdData[15:0] = div_q;
`ifdef UART_TX_IRQ_EN
        UART_OFS_IE:  RdData[0]    = ie_q;
`endif
        default: RdData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, frame timing, FIFO overflow,
// divisor updates, mid-frame reset and (with UART_TX_IRQ_EN) the interrupt.
module tb_uart_tx_mmio;

  localparam logic [31:0] A_TX  = 32'h0000_1000;
  localparam logic [31:0] A_ST  = 32'h0000_1004;
  localparam logic [31:0] A_DIV = 32'h0000_1008;
  localparam logic [31:0] A_IE  = 32'h0000_100C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] DataWr = '0;
  logic        DMWr = 1'b0;
  logic        Sel;
  logic [31:0] RdData;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .clk     (clk),
    .rst     (rst),
    .Address (Address),
    .DataWr  (DataWr),
    .DMWr    (DMWr),
    .Sel     (Sel),
    .RdData  (RdData),
    .tx      (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a;
    DataWr  = d;
    DMWr    = 1'b1;
    @(negedge clk);
    DMWr    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    DMWr    = 1'b0;
    #1;
    d = RdData;
  endtask

  // Samples one frame, one sample per clock, starting at the first START sample.
  task automatic frame(input string tag, input logic [7:0] b, input int d0, input int d1);
    int   bad;
    logic e;
    bad = 0;
    for (int k = 0; k < d0 + 9 * d1; k++) begin
      if (k < d0)               e = 1'b0;
      else if (k < d0 + 8 * d1) e = b[(k - d0) / d1];
      else                      e = 1'b1;
      if (tx !== e) bad++;
      @(negedge clk);
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          n;

    repeat (3) @(negedge clk);
    chk("rst_tx_held", 32'(tx), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rd(A_ST, r);        chk("rst_status", r, 32'h04);
    rd(A_DIV, r);       chk("rst_div", r, 32'd434);
    chk("sel_hit", 32'(Sel), 32'd1);
    rd(A_TX, r);        chk("txdata_rd0", r, 32'd0);
    rd(32'h0000_2008, r);
    chk("sel_miss", 32'(Sel), 32'd0);
    chk("miss_rd0", r, 32'd0);

    // 0x55 at DIV=4, with exact push-to-start latency
    wr(A_DIV, 32'd4);
    rd(A_DIV, r);       chk("div4_rd", r, 32'd4);
    wr(A_TX, 32'h55);
    rd(A_ST, r);        chk("st_queued", r, 32'h10);
    chk("tx_before_start", 32'(tx), 32'd1);
    @(negedge clk);
    frame("frame_55", 8'h55, 4, 4);
    chk("tx_idle_after", 32'(tx), 32'd1);
    rd(A_ST, r);        chk("st_after_55", r, 32'h04);

    // nine back-to-back bytes at DIV=2, no idle gap between frames
    wr(A_DIV, 32'd2);
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          Address = A_TX;
          DataWr  = 32'hA0 + 32'(i);
          DMWr    = 1'b1;
          @(negedge clk);
        end
        DMWr = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < 20) begin
          @(negedge clk);
          w++;
        end
        chk("b2b_fall", 32'(tx), 32'd0);
        for (int i = 0; i < 9; i++) frame("b2b_frame", 8'hA0 + 8'(i), 2, 2);
      end
    join
    rd(A_ST, r);        chk("b2b_status", r, 32'h04);

    // ten back-to-back bytes: tenth dropped, OVF sticky until STATUS write
    for (int i = 0; i < 10; i++) begin
      Address = A_TX;
      DataWr  = 32'h30 + 32'(i);
      DMWr    = 1'b1;
      @(negedge clk);
    end
    DMWr = 1'b0;
    rd(A_ST, r);        chk("ovf_status", r, 32'h8B);
    wr(A_ST, 32'd0);
    rd(A_ST, r);        chk("ovf_cleared", r, 32'h83);
    n = 0;
    rd(A_ST, r);
    while (r != 32'h04 && n < 500) begin
      @(negedge clk);
      rd(A_ST, r);
      n++;
    end
    chk("ovf_drain", r, 32'h04);

    // DIV=0 stored as 1, frame is 10 clocks
    wr(A_DIV, 32'd0);
    rd(A_DIV, r);       chk("div0_rd", r, 32'd1);
    wr(A_TX, 32'hA3);
    @(negedge clk);
    frame("frame_div1", 8'hA3, 1, 1);
    rd(A_ST, r);        chk("st_after_div1", r, 32'h04);

    // DIV 8 -> 3 during START: START keeps 8, the rest use 3
    wr(A_DIV, 32'd8);
    wr(A_TX, 32'hC6);
    @(negedge clk);
    fork
      frame("frame_divchg", 8'hC6, 8, 3);
      begin
        @(negedge clk);
        @(negedge clk);
        wr(A_DIV, 32'd3);
      end
    join
    rd(A_DIV, r);       chk("div3_rd", r, 32'd3);
    rd(A_ST, r);        chk("st_after_chg", r, 32'h04);

    // reset during DATA bit 3 of 0xF7 with more bytes queued
    for (int i = 0; i < 3; i++) begin
      Address = A_TX;
      DataWr  = (i == 0) ? 32'hF7 : 32'h11 * 32'(i);
      DMWr    = 1'b1;
      @(negedge clk);
    end
    DMWr = 1'b0;
    repeat (12) @(negedge clk);
    chk("bit3_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rd(A_ST, r);        chk("rst_mid_status", r, 32'h04);
    rd(A_DIV, r);       chk("rst_mid_div", r, 32'd434);
    repeat (30) @(negedge clk);
    chk("flush_tx", 32'(tx), 32'd1);
    rd(A_ST, r);        chk("flush_status", r, 32'h04);

    // unmapped offsets and out-of-window writes are ignored
    wr(32'h0000_1009, 32'd5);
    wr(32'h0000_1018, 32'd7);
    rd(A_DIV, r);       chk("ign_div", r, 32'd434);
    rd(32'h0000_1001, r); chk("ofs1_rd0", r, 32'd0);

`ifdef UART_TX_IRQ_EN
    wr(A_DIV, 32'd2);
    wr(A_IE, 32'd1);
    rd(A_IE, r);        chk("ie_rd", r, 32'd1);
    @(negedge clk);
    chk("irq_idle", 32'(irq), 32'd1);
    wr(A_TX, 32'h5A);
    @(negedge clk);
    chk("irq_in_frame", 32'(irq), 32'd0);
    frame("frame_irq", 8'h5A, 2, 2);
    chk("irq_stop_end", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_after", 32'(irq), 32'd1);
`else
    wr(A_IE, 32'd1);
    rd(A_IE, r);        chk("ie_absent", r, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
